// File: rtl/bmf_pkg.sv
// Shared constants, basis-row typedef and arithmetic helpers for the BMF
// decoder and its compressor-side checker.
package bmf_pkg;

  localparam int unsigned K_DEF  = 3;
  localparam int unsigned M_DEF  = 4;
  localparam int unsigned CW_DEF = 16;

  // Basis matrix H at the default geometry, one M-bit row per code bit
  typedef logic [M_DEF-1:0] h_rows_t [K_DEF];

  function automatic int unsigned popcount(input logic [31:0] x);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(x[i]);
    end
    return n;
  endfunction

  // a + b clamped to 2^w - 1 (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/bmf_decoder_stream_if.sv
// Config, input-code and decoded-output handshakes of the BMF decoder.
// master = upstream/downstream environment, slave = decoder.
interface bmf_decoder_stream_if #(
  parameter int unsigned K = bmf_pkg::K_DEF,
  parameter int unsigned M = bmf_pkg::M_DEF
);
  localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;

  logic          cfg_we;
  logic [RW-1:0] cfg_row;
  logic [M-1:0]  cfg_data;
  logic          cfg_ready;

  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_code;
  logic [M-1:0]  in_ref;

  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_data;
  logic          out_err;

  modport master (
    output cfg_we, cfg_row, cfg_data, in_valid, in_code, in_ref, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  cfg_we, cfg_row, cfg_data, in_valid, in_code, in_ref, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/bmf_bool_product.sv
// Combinational Boolean product of a K-bit code with a K x M basis matrix:
// prod_c[m] = OR_j (code[j] AND H[j][m]); row j lives at h_flat[j*M +: M].
module bmf_bool_product
  import bmf_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned M = M_DEF
) (
  input  logic [K-1:0]   code,
  input  logic [K*M-1:0] h_flat,
  output logic [M-1:0]   prod_c
);

  always_comb begin
    prod_c = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (code[j]) begin
        prod_c = prod_c | h_flat[j*M +: M];
      end
    end
  end

endmodule

// File: rtl/bmf_decoder_stream.sv
// Streaming BMF decoder: programmable basis H, one-entry output register with
// full throughput, and saturating mismatch / Hamming-distance counters.
module bmf_decoder_stream
  import bmf_pkg::*;
#(
  parameter int unsigned   K       = K_DEF,
  parameter int unsigned   M       = M_DEF,
  parameter int unsigned   CW      = CW_DEF,
  parameter logic [K*M-1:0] H_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  bmf_decoder_stream_if.slave    bus,
  input  logic                   err_clr,
  output logic [CW-1:0]          err_count,
  output logic [CW-1:0]          hd_sum
);

  localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;

  logic [K*M-1:0] h_q, h_d;
  logic           out_valid_q, out_valid_d;
  logic [M-1:0]   out_data_q, out_data_d;
  logic           out_err_q, out_err_d;
  logic [CW-1:0]  err_count_q, err_count_d;
  logic [CW-1:0]  hd_sum_q, hd_sum_d;

  logic           cfg_fire_c, in_ready_c, in_fire_c, out_fire_c;
  logic [M-1:0]   prod_c;
  logic           mism_c;
  logic [31:0]    hd_c;

  bmf_bool_product #(.K(K), .M(M)) u_prod (
    .code   (bus.in_code),
    .h_flat (h_q),
    .prod_c (prod_c)
  );

  // Config only while the output register is empty, and it wins over input
  assign cfg_fire_c = bus.cfg_we && !out_valid_q;
  assign in_ready_c = (!out_valid_q || bus.out_ready) && !cfg_fire_c;
  assign in_fire_c  = bus.in_valid && in_ready_c;
  assign out_fire_c = out_valid_q && bus.out_ready;

  assign mism_c = (prod_c != bus.in_ref);
  assign hd_c   = 32'(popcount(32'(prod_c ^ bus.in_ref)));

  always_comb begin
    h_d         = h_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    hd_sum_d    = hd_sum_q;

    // Out-of-range rows match no j and are dropped
    for (int unsigned j = 0; j < K; j++) begin
      if (cfg_fire_c && (bus.cfg_row == RW'(j))) begin
        h_d[j*M +: M] = bus.cfg_data;
      end
    end

    if (in_fire_c) begin
      out_valid_d = 1'b1;
      out_data_d  = prod_c;
      out_err_d   = mism_c;
    end else if (out_fire_c) begin
      out_valid_d = 1'b0;
    end

    // Clear first, so a same-cycle word contributes alone
    if (err_clr) begin
      err_count_d = '0;
      hd_sum_d    = '0;
    end
    if (in_fire_c) begin
      err_count_d = CW'(sat_add(32'(err_count_d), {31'b0, mism_c}, CW));
      hd_sum_d    = CW'(sat_add(32'(hd_sum_d), hd_c, CW));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q         <= H_RESET;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
      hd_sum_q    <= '0;
    end else begin
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
      hd_sum_q    <= hd_sum_d;
    end
  end

  assign bus.cfg_ready = !out_valid_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign err_count     = err_count_q;
  assign hd_sum        = hd_sum_q;

endmodule

// File: doc/bmf_decoder_stream.md
# bmf_decoder_stream

Streaming Boolean-matrix-factorisation decoder: the decompression end of a BMF-partitioned approximate subcircuit. It accepts K-bit factor codes from a compressor stage and reconstructs M-bit outputs as the Boolean product of the code and a programmable K×M basis matrix H, so that out[m] = OR over j of (code[j] AND H[j][m]). It sits behind a compressor in the approximate-logic evaluation datapath. It also accumulates error statistics against an exact reference word supplied alongside each code.

## Interface
- K, 3, code width (number of basis rows)
- M, 4, output width
- CW, 16, error counter width
- H_RESET, {K*M{1'b0}}, reset contents of H; row j at bits [j*M +: M]
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  write one basis row
- cfg_row  in  $clog2(K)  row index
- cfg_data  in  M  row contents
- cfg_ready  out  1  configuration write can be accepted
- in_valid  in  1  code/reference present
- in_ready  out  1  decoder can accept
- in_code  in  K  factor code
- in_ref  in  M  exact reference output for this code
- out_valid  out  1  decoded word present
- out_ready  in  1  downstream accepts
- out_data  out  M  decoded word
- out_err  out  1  out_data differs from its in_ref
- err_clr  in  1  synchronous clear of both counters
- err_count  out  CW  number of mismatching words, saturating
- hd_sum  out  CW  sum of Hamming distances, saturating

## Operation
- Input handshake fires when in_valid && in_ready; output handshake fires when out_valid && out_ready.
- On input fire: d = Boolean product of in_code and H; out_data <= d, out_err <= (d != in_ref), out_valid <= 1.
- in_ready = (!out_valid || out_ready) && !(cfg_we && cfg_ready); one-entry output register with full throughput.
- out_valid clears on output fire without a simultaneous input fire.
- cfg_ready = !out_valid; H never changes under a word in flight.
- Config write fires when cfg_we && cfg_ready: H[cfg_row] <= cfg_data. Config beats input in the same cycle; in_ready is 0 that cycle.
- cfg_row >= K: write ignored; no state change.
- Counters update on input fire, not output fire. err_count increments when d != in_ref. hd_sum adds popcount(d ^ in_ref). Both saturate at 2^CW-1 and never wrap.
- err_clr zeroes both counters. If an input fires in the same cycle, the counters take that word's contribution alone: 0 or 1, and 0 or the popcount.
- All-zero code: d = 0 for any H.

## Timing
- Latency: code accepted at edge n appears on out_data/out_err after edge n, valid in cycle n+1.
- Throughput: one word per cycle while out_ready is held high.
- out_data and out_err are held stable while out_valid && !out_ready.
- Counter values reflect a word one cycle after its input fire.
- Reset, asserted at any time, including mid-stream: out_valid=0, out_data=0, out_err=0, err_count=0, hd_sum=0, H=H_RESET. cfg_ready=1 and in_ready=1 once rst deasserts. An in-flight word is dropped.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready and cfg_we only.

## Structure
- Shared package bmf_pkg: default K/M/CW constants, typedef for the H row array, popcount function, saturating-add function.
- One sub-module, bmf_bool_product: purely combinational code×H → M-bit word, reused by the compressor-side checker.
- The top holds the H register file, the output register with handshake, and the counters.

## Test plan
- Program H rows 4'b0010, 4'b0100, 4'b1000; code 3'b101 with ref 4'b1010 -> out_data=4'b1010, out_err=0, counters unchanged.
- Same H; codes 3'b111 then 3'b011, refs 4'b1111 and 4'b0110 -> outputs 4'b1110 and 4'b0110; err_count=1, hd_sum=1.
- Random valids with out_ready stalled 3 cycles -> out_data held stable; no word lost or duplicated; cfg_ready=0 while a word is held; a cfg_we during the stall has no effect.
- cfg_we and in_valid in the same cycle with cfg_ready=1 -> row written, in_ready=0; the next accepted code decodes with the new row.
- CW=4: 20 mismatching words, each Hamming distance 4 -> err_count=15, hd_sum=15 (saturated). err_clr together with one mismatching word of distance 2 -> err_count=1, hd_sum=2.
- Assert rst while out_valid=1 with a modified H -> all outputs 0 and H=H_RESET; code 3'b111 then decodes to 4'b0000 with default H_RESET.
